// File: rtl/twiddle_angle_seq.sv
// Streams float32 CORDIC twiddle angles for any radix-2 stage of a 2^MAX_LOG2N-point FFT.
// One element per cycle over valid/ready; the output register doubles as the table read register.
module twiddle_angle_seq #(
  parameter int MAX_LOG2N = 7,
  parameter int STG_W     = $clog2(MAX_LOG2N + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [STG_W-1:0]     i_stage,
  input  logic                 i_inverse,
  input  logic                 i_ready,
  output logic [31:0]          o_data,
  output logic                 o_valid,
  output logic [MAX_LOG2N-2:0] o_k,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);
  localparam int KW = MAX_LOG2N - 1;
  localparam int T  = 1 << KW;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

  // Round the double -j*pi/T to the nearest float32 (ties to even).
  function automatic logic [31:0] ang_f32(input int j);
    real         a;
    logic [63:0] b;
    logic [23:0] m;
    logic [7:0]  e;
    if (j == 0) return 32'h0;
    a = -(real'(j) * 3.14159265358979323846) / real'(T);
    b = $realtobits(a);
    m = {1'b0, b[51:29]};
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 24'd1;
    e = 8'(int'(b[62:52]) - 896 + int'(m[23]));
    return {b[63], e, m[22:0]};
  endfunction

  function automatic logic [(1<<STG_W)-1:0] legal_mask();
    logic [(1<<STG_W)-1:0] msk;
    msk = '0;
    for (int i = 1; i <= MAX_LOG2N; i++) msk[i] = 1'b1;
    return msk;
  endfunction

  localparam logic [(1<<STG_W)-1:0] LEGAL = legal_mask();

  logic [31:0] rom [T];
  for (genvar j = 0; j < T; j++) begin : g_rom
    localparam logic [31:0] ENT = ang_f32(j);
    assign rom[j] = ENT;
  end

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    n_q, n_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic             inv_q, inv_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [KW-1:0]    k_q, k_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             done;

  logic             ld, ld_inv;
  logic [STG_W-1:0] ld_stg, sh;
  logic [KW-1:0]    ld_n, kmask, kv, idx;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    stg_d   = stg_q;
    inv_d   = inv_q;
    data_d  = data_q;
    valid_d = valid_q;
    k_d     = k_q;
    last_d  = last_q;
    err_d   = 1'b0;
    done    = 1'b0;
    ld      = 1'b0;
    ld_stg  = stg_q;
    ld_inv  = inv_q;
    ld_n    = n_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (LEGAL[i_stage]) begin
            // Element 0 is loaded on the accepting edge so it is visible next cycle.
            ld     = 1'b1;
            ld_stg = i_stage;
            ld_inv = i_inverse;
            ld_n   = '0;
            stg_d  = i_stage;
            inv_d  = i_inverse;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN:   ld = !valid_q || i_ready;
      S_DRAIN: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // k is the low (s-1) bits of the flat element count; the table index is k scaled to T.
    sh    = STG_W'(MAX_LOG2N) - ld_stg;
    kmask = {KW{1'b1}} >> sh;
    kv    = ld_n & kmask;
    idx   = kv << sh;

    if (ld) begin
      data_d  = rom[idx] ^ {ld_inv && (kv != '0), 31'b0};
      k_d     = kv;
      valid_d = 1'b1;
      last_d  = (ld_n == KW'(T - 1));
      if (ld_n == KW'(T - 1)) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_RUN;
        n_d     = ld_n + KW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      stg_q   <= '0;
      inv_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      k_q     <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      stg_q   <= stg_d;
      inv_q   <= inv_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      k_q     <= k_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_k     = k_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done;
  assign o_err   = err_q;
endmodule
